// File: rtl/span_interpolator.sv
// Span interpolator: walks an inclusive pixel span on one row, emitting one fragment
// per x with linearly accumulated attributes and a floor-clamped w alongside.
package span_interpolator_pkg;
    localparam int unsigned COORD_W = 16;
    localparam int unsigned FP_W    = 32;
    localparam int unsigned N_ATTR  = 7;

    typedef logic [COORD_W-1:0] screen_coord_t;
    typedef logic [FP_W-1:0]    fp32_t;
    typedef fp32_t [0:N_ATTR-1] attr_vec_t;

    typedef struct packed {
        logic          valid;
        screen_coord_t x;
        screen_coord_t y;
        fp32_t         z;
        fp32_t         u;
        fp32_t         v;
        fp32_t         r;
        fp32_t         g;
        fp32_t         b;
    } fragment_t;

    localparam fp32_t W_FLOOR = 32'h0000_1000;
endpackage

module span_interpolator
    import span_interpolator_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          span_valid,
    output logic          span_ready,
    input  screen_coord_t span_x_start,
    input  screen_coord_t span_x_end,
    input  screen_coord_t span_y,
    input  attr_vec_t     span_attr,
    input  attr_vec_t     span_dattr,
    output fragment_t     frag_out,
    output fp32_t         w_out,
    output logic          frag_out_valid,
    input  logic          frag_out_ready,
    output logic          span_done
);
    localparam int unsigned A_Z = 0;
    localparam int unsigned A_U = 1;
    localparam int unsigned A_V = 2;
    localparam int unsigned A_R = 3;
    localparam int unsigned A_G = 4;
    localparam int unsigned A_B = 5;
    localparam int unsigned A_W = 6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    fragment_t     frag_q, frag_d;
    fp32_t         w_acc_q, w_acc_d;
    fp32_t         w_out_q, w_out_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    screen_coord_t x_end_q, x_end_d;
    attr_vec_t     dattr_q, dattr_d;
    logic          xfer_c;
    logic          last_xfer_c;

    // Keeps w away from zero/negative so the downstream reciprocal stays bounded.
    function automatic fp32_t clamp_w(input fp32_t w);
        return ($signed(w) > $signed(W_FLOOR)) ? w : W_FLOOR;
    endfunction

    always_comb begin
        state_d     = state_q;
        frag_d      = frag_q;
        w_acc_d     = w_acc_q;
        w_out_d     = w_out_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        x_end_d     = x_end_q;
        dattr_d     = dattr_q;
        xfer_c      = valid_q && frag_out_ready;
        last_xfer_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (span_valid) begin
                    if (span_x_end >= span_x_start) begin
                        x_end_d      = span_x_end;
                        dattr_d      = span_dattr;
                        frag_d.valid = 1'b1;
                        frag_d.x     = span_x_start;
                        frag_d.y     = span_y;
                        frag_d.z     = span_attr[A_Z];
                        frag_d.u     = span_attr[A_U];
                        frag_d.v     = span_attr[A_V];
                        frag_d.r     = span_attr[A_R];
                        frag_d.g     = span_attr[A_G];
                        frag_d.b     = span_attr[A_B];
                        w_acc_d      = span_attr[A_W];
                        w_out_d      = clamp_w(span_attr[A_W]);
                        valid_d      = 1'b1;
                        state_d      = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // Advance only on a transfer so a stalled fragment stays bit-stable.
                if (xfer_c) begin
                    if (frag_q.x == x_end_q) begin
                        valid_d     = 1'b0;
                        last_xfer_c = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        frag_d.x = frag_q.x + COORD_W'(1);
                        frag_d.z = frag_q.z + dattr_q[A_Z];
                        frag_d.u = frag_q.u + dattr_q[A_U];
                        frag_d.v = frag_q.v + dattr_q[A_V];
                        frag_d.r = frag_q.r + dattr_q[A_R];
                        frag_d.g = frag_q.g + dattr_q[A_G];
                        frag_d.b = frag_q.b + dattr_q[A_B];
                        w_acc_d  = w_acc_q + dattr_q[A_W];
                        w_out_d  = clamp_w(w_acc_d);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            frag_q  <= '0;
            w_acc_q <= '0;
            w_out_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            x_end_q <= '0;
            dattr_q <= '0;
        end else begin
            state_q <= state_d;
            frag_q  <= frag_d;
            w_acc_q <= w_acc_d;
            w_out_q <= w_out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            x_end_q <= x_end_d;
            dattr_q <= dattr_d;
        end
    end

    // Empty spans finish one cycle after accept; real spans finish on the last transfer.
    assign span_ready     = (state_q == IDLE);
    assign frag_out       = frag_q;
    assign w_out          = w_out_q;
    assign frag_out_valid = valid_q;
    assign span_done      = done_q | last_xfer_c;

endmodule

// File: tb/tb_span_interpolator.sv
// Bench for span_interpolator: directed table, hand-written corner sequences and
// randomized spans scored against a closed-form per-pixel reference.
module tb_span_interpolator;
    import span_interpolator_pkg::*;

    typedef struct {
        fragment_t f;
        fp32_t     w;
        bit        last;
    } exp_t;

    typedef struct {
        screen_coord_t xs;
        screen_coord_t xe;
        fp32_t         uw;
        fp32_t         duw;
        fp32_t         w;
        fp32_t         dw;
        int            n;
        fp32_t         u_last;
        fp32_t         w_last;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          span_valid = 1'b0;
    logic          span_ready;
    screen_coord_t span_x_start = '0;
    screen_coord_t span_x_end = '0;
    screen_coord_t span_y = '0;
    attr_vec_t     span_attr = '0;
    attr_vec_t     span_dattr = '0;
    fragment_t     frag_out;
    fp32_t         w_out;
    logic          frag_out_valid;
    logic          frag_out_ready = 1'b1;
    logic          span_done;

    span_interpolator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .span_valid    (span_valid),
        .span_ready    (span_ready),
        .span_x_start  (span_x_start),
        .span_x_end    (span_x_end),
        .span_y        (span_y),
        .span_attr     (span_attr),
        .span_dattr    (span_dattr),
        .frag_out      (frag_out),
        .w_out         (w_out),
        .frag_out_valid(frag_out_valid),
        .frag_out_ready(frag_out_ready),
        .span_done     (span_done)
    );

    always #5 clk = ~clk;

    int        n_checks = 0;
    int        n_fail = 0;
    exp_t      exp_q[$];
    int        frags_seen = 0;
    int        done_seen = 0;
    fp32_t     last_u = '0;
    fp32_t     last_w = '0;
    int        cyc = 0;
    int        xfer_cyc[$];
    logic      stall_pend = 1'b0;
    fragment_t held_f;
    fp32_t     held_w;
    int        ready_mode = 0;
    int        tog_idx = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Reference: pixel i of a span carries start + i*delta, wrapping at 32 bits.
    task automatic model_span(input screen_coord_t xs, input screen_coord_t xe, input screen_coord_t y,
                              input attr_vec_t a, input attr_vec_t d);
        exp_t  e;
        fp32_t acc [0:6];
        int    n;
        if (xe < xs) return;
        n = int'(xe) - int'(xs) + 1;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 7; k++) acc[k] = a[k] + fp32_t'(i) * d[k];
            e.f.valid = 1'b1;
            e.f.x     = xs + screen_coord_t'(i);
            e.f.y     = y;
            e.f.z     = acc[0];
            e.f.u     = acc[1];
            e.f.v     = acc[2];
            e.f.r     = acc[3];
            e.f.g     = acc[4];
            e.f.b     = acc[5];
            e.w       = ($signed(acc[6]) < $signed(32'h0000_1000)) ? 32'h0000_1000 : acc[6];
            e.last    = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    always @(posedge clk) cyc++;

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       frag_out_ready = 1'b1;
            1:       begin frag_out_ready = ((tog_idx % 3) == 0); tog_idx++; end
            default: frag_out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: scoreboard every transfer and confirm stalled payloads hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_hold_frag", 256'(frag_out), 256'(held_f));
                check("stall_hold_w", 256'(w_out), 256'(held_w));
                check("stall_hold_valid", 256'(frag_out_valid), 256'(1));
            end
            stall_pend = frag_out_valid && !frag_out_ready;
            if (stall_pend) begin
                held_f = frag_out;
                held_w = w_out;
            end
            if (span_done) done_seen++;
            if (frag_out_valid && frag_out_ready) begin
                frags_seen++;
                last_u = frag_out.u;
                last_w = w_out;
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_frag", 256'(frag_out_valid), 256'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("frag", 256'(frag_out), 256'(e.f));
                    check("w_out", 256'(w_out), 256'(e.w));
                    check("done_on_xfer", 256'(span_done), 256'(e.last));
                end
            end
        end
    end

    task automatic send_span(input screen_coord_t xs, input screen_coord_t xe, input screen_coord_t y,
                             input attr_vec_t a, input attr_vec_t d);
        int t = 0;
        model_span(xs, xe, y, a, d);
        while (!span_ready && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!span_ready) check("span_ready_timeout", 256'(span_ready), 256'(1));
        span_x_start = xs;
        span_x_end   = xe;
        span_y       = y;
        span_attr    = a;
        span_dattr   = d;
        span_valid   = 1'b1;
        @(posedge clk);
        #1;
        // Scramble the descriptor after accept; the span in flight must not notice.
        span_valid   = 1'b0;
        span_x_start = screen_coord_t'($urandom);
        span_x_end   = screen_coord_t'($urandom);
        span_y       = screen_coord_t'($urandom);
        for (int k = 0; k < 7; k++) begin
            span_attr[k]  = $urandom;
            span_dattr[k] = $urandom;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || !span_ready) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain", 256'(exp_q.size()), 256'(0));
        @(posedge clk);
        #1;
    endtask

    function automatic attr_vec_t mk_attr(input fp32_t uw, input fp32_t w);
        attr_vec_t a;
        for (int k = 0; k < 7; k++) a[k] = $urandom;
        a[1] = uw;
        a[6] = w;
        return a;
    endfunction

    vec_t tbl[6];

    initial begin
        attr_vec_t a, d;
        screen_coord_t xs, xe;
        int nspans;

        tbl[0] = '{16'd10, 16'd13, 32'h0001_0000, 32'h0000_8000, 32'h0001_0000, 32'h0, 4, 32'h0002_8000, 32'h0001_0000};
        tbl[1] = '{16'd0, 16'd3, 32'h0, 32'h0, 32'h0000_2000, 32'hFFFF_F000, 4, 32'h0, 32'h0000_1000};
        tbl[2] = '{16'd100, 16'd100, 32'h0000_1234, 32'h5, 32'h0000_5000, 32'h0, 1, 32'h0000_1234, 32'h0000_5000};
        tbl[3] = '{16'd0, 16'd1, 32'hFFFF_FFFF, 32'h1, 32'h7FFF_FFFF, 32'h1, 2, 32'h0, 32'h0000_1000};
        tbl[4] = '{16'hFFFE, 16'hFFFF, 32'h0, 32'h10, 32'h0000_1000, 32'h0, 2, 32'h10, 32'h0000_1000};
        tbl[5] = '{16'd7, 16'd3, 32'h1, 32'h1, 32'h1, 32'h1, 0, 32'h0, 32'h0};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_frag", 256'(frag_out), 256'(0));
        check("rst_w", 256'(w_out), 256'(0));
        check("rst_valid", 256'(frag_out_valid), 256'(0));
        check("rst_done", 256'(span_done), 256'(0));
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", 256'(span_ready), 256'(1));

        // Directed table, ready held high
        foreach (tbl[i]) begin
            frags_seen = 0;
            done_seen  = 0;
            a = mk_attr(tbl[i].uw, tbl[i].w);
            d = mk_attr(tbl[i].duw, tbl[i].dw);
            send_span(tbl[i].xs, tbl[i].xe, 16'd5, a, d);
            wait_drain();
            check($sformatf("tbl%0d_count", i), 256'(frags_seen), 256'(tbl[i].n));
            check($sformatf("tbl%0d_done", i), 256'(done_seen), 256'(1));
            if (tbl[i].n > 0) begin
                check($sformatf("tbl%0d_u_last", i), 256'(last_u), 256'(tbl[i].u_last));
                check($sformatf("tbl%0d_w_last", i), 256'(last_w), 256'(tbl[i].w_last));
            end
        end

        // Same span under a 1,0,0 ready pattern
        ready_mode = 1;
        frags_seen = 0;
        send_span(16'd10, 16'd13, 16'd5, mk_attr(32'h0001_0000, 32'h0001_0000), mk_attr(32'h0000_8000, 32'h0));
        wait_drain();
        check("stall_count", 256'(frags_seen), 256'(4));
        check("stall_u_last", 256'(last_u), 256'(32'h0002_8000));
        ready_mode = 0;
        @(posedge clk);
        #1;

        // Empty span: done one cycle after accept, ready stays high
        done_seen = 0;
        frags_seen = 0;
        span_x_start = 16'd7;
        span_x_end   = 16'd3;
        span_valid   = 1'b1;
        check("empty_ready_pre", 256'(span_ready), 256'(1));
        check("empty_done_pre", 256'(span_done), 256'(0));
        @(posedge clk);
        #1;
        span_valid = 1'b0;
        check("empty_done", 256'(span_done), 256'(1));
        check("empty_ready", 256'(span_ready), 256'(1));
        check("empty_valid", 256'(frag_out_valid), 256'(0));
        @(posedge clk);
        #1;
        check("empty_done_clr", 256'(span_done), 256'(0));
        check("empty_frags", 256'(frags_seen), 256'(0));

        // Reset after the 2nd fragment of a 6-pixel span
        frags_seen = 0;
        send_span(16'd20, 16'd25, 16'd9, mk_attr(32'h100, 32'h8000), mk_attr(32'h10, 32'h0));
        for (int t = 0; t < 100 && frags_seen < 2; t++) begin
            @(negedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("midrst_frag", 256'(frag_out), 256'(0));
        check("midrst_w", 256'(w_out), 256'(0));
        check("midrst_valid", 256'(frag_out_valid), 256'(0));
        check("midrst_done", 256'(span_done), 256'(0));
        check("midrst_ready", 256'(span_ready), 256'(1));
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_frags", 256'(frags_seen), 256'(2));
        frags_seen = 0;
        send_span(16'd30, 16'd32, 16'd1, mk_attr(32'h0, 32'h2_0000), mk_attr(32'h1, 32'h0));
        wait_drain();
        check("postrst_count", 256'(frags_seen), 256'(3));

        // Back-to-back single-pixel spans
        xfer_cyc.delete();
        send_span(16'd50, 16'd50, 16'd2, mk_attr(32'h1, 32'h2000), mk_attr(32'h0, 32'h0));
        send_span(16'd60, 16'd60, 16'd3, mk_attr(32'h2, 32'h3000), mk_attr(32'h0, 32'h0));
        wait_drain();
        check("b2b_count", 256'(xfer_cyc.size()), 256'(2));
        if (xfer_cyc.size() == 2) check("b2b_gap", 256'(xfer_cyc[1] - xfer_cyc[0]), 256'(2));

        // Randomized spans with random backpressure
        ready_mode = 2;
        done_seen  = 0;
        nspans     = 30;
        for (int s = 0; s < nspans; s++) begin
            xs = screen_coord_t'($urandom_range(5, 2000));
            if ($urandom_range(0, 7) == 0) xe = xs - screen_coord_t'($urandom_range(1, 5));
            else xe = xs + screen_coord_t'($urandom_range(0, 9));
            for (int k = 0; k < 7; k++) begin
                a[k] = $urandom;
                d[k] = $urandom;
            end
            if ($urandom_range(0, 1) == 1) begin
                a[6] = fp32_t'($urandom_range(0, 32'h3000));
                d[6] = 32'hFFFF_FC00;
            end
            send_span(xs, xe, screen_coord_t'($urandom), a, d);
            if ($urandom_range(0, 3) == 0) wait_drain();
        end
        wait_drain();
        check("rand_done_count", 256'(done_seen), 256'(nspans));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule
